// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with double-buffered BCD display and leading-zero blanking.
// Define SEG_HEX_DECODE_EN to show hex glyphs for codes 10..15 instead of blanking them.
module seg_scan_driver #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lzb_en,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

   logic [CW-1:0]             cnt_q, cnt_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0]   sh_bcd_q, sh_bcd_d, dsp_bcd_q, dsp_bcd_d;
   logic [NUM_DIGITS-1:0]     sh_dp_q, sh_dp_d, dsp_dp_q, dsp_dp_d;
   logic                      sh_lzb_q, sh_lzb_d, dsp_lzb_q, dsp_lzb_d;
   logic [6:0]                seg_q, seg_d;
   logic                      dp_q, dp_d;
   logic [NUM_DIGITS-1:0]     an_q, an_d;
   logic                      frame_done_q, frame_done_d;
   logic                      slot_wrap, frame_wrap, zero_run;
   logic [NUM_DIGITS-1:0]     blank;
   logic [3:0]                cur_digit;

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'd0: decode = 7'b1111110;
         4'd1: decode = 7'b0110000;
         4'd2: decode = 7'b1101101;
         4'd3: decode = 7'b1111001;
         4'd4: decode = 7'b0110011;
         4'd5: decode = 7'b1011011;
         4'd6: decode = 7'b0011111;
         4'd7: decode = 7'b1110000;
         4'd8: decode = 7'b1111111;
         4'd9: decode = 7'b1110011;
`ifdef SEG_HEX_DECODE_EN
         4'd10: decode = 7'b1110111;
         4'd11: decode = 7'b0011111;
         4'd12: decode = 7'b1001110;
         4'd13: decode = 7'b0111101;
         4'd14: decode = 7'b1001111;
         4'd15: decode = 7'b1000111;
`else
         default: decode = 7'b0000000;
`endif
      endcase
   endfunction

   always_comb begin
      slot_wrap  = (cnt_q == CNT_MAX);
      frame_wrap = slot_wrap && (idx_q == IDX_MAX);
      cnt_d      = slot_wrap ? '0 : cnt_q + CW'(1);
      idx_d      = idx_q;
      if (slot_wrap) idx_d = frame_wrap ? '0 : idx_q + IW'(1);

      sh_bcd_d = sh_bcd_q;
      sh_dp_d  = sh_dp_q;
      sh_lzb_d = sh_lzb_q;
      if (load) begin
         sh_bcd_d = bcd_in;
         sh_dp_d  = dp_in;
         sh_lzb_d = lzb_en;
      end

      // Display only changes at frame wrap; a coincident load bypasses the shadow.
      dsp_bcd_d = dsp_bcd_q;
      dsp_dp_d  = dsp_dp_q;
      dsp_lzb_d = dsp_lzb_q;
      if (frame_wrap) begin
         dsp_bcd_d = sh_bcd_d;
         dsp_dp_d  = sh_dp_d;
         dsp_lzb_d = sh_lzb_d;
      end

      // Scan from the top digit down: blank while every digit so far is zero.
      zero_run = 1'b1;
      blank    = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run = zero_run && (dsp_bcd_d[4*k +: 4] == 4'd0);
         blank[k] = dsp_lzb_d && zero_run && (k != 0);
      end

      // Outputs are computed from next state so they line up with cnt_q/idx_q.
      cur_digit    = dsp_bcd_d[4*int'(idx_d) +: 4];
      seg_d        = blank[idx_d] ? 7'b0000000 : decode(cur_digit);
      dp_d         = dsp_dp_d[idx_d];
      an_d         = '0;
      if (cnt_d != '0) an_d[idx_d] = 1'b1;
      frame_done_d = frame_wrap;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         sh_bcd_q     <= '0;
         sh_dp_q      <= '0;
         sh_lzb_q     <= 1'b0;
         dsp_bcd_q    <= '0;
         dsp_dp_q     <= '0;
         dsp_lzb_q    <= 1'b0;
         seg_q        <= '0;
         dp_q         <= 1'b0;
         an_q         <= '0;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         sh_bcd_q     <= sh_bcd_d;
         sh_dp_q      <= sh_dp_d;
         sh_lzb_q     <= sh_lzb_d;
         dsp_bcd_q    <= dsp_bcd_d;
         dsp_dp_q     <= dsp_dp_d;
         dsp_lzb_q    <= dsp_lzb_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;
endmodule
